// File: rtl/ccsds_turbo_dec_depunct.sv
// ---------------------------------------------------------------------------
// ccsds_turbo_dec_depunct
//
// Front end of the CCSDS turbo decoder. It takes one trellis step of received
// soft symbols per accept, re-inserts erasures (0) for the streams the
// encoder's puncturing did not transmit, and emits a fixed six-symbol bundle
// {0a,1a,2a,3a,1b,3b}. It also tags each bundle with start-of-frame,
// end-of-frame and termination (tail) flags. Bundles pass through a 2-entry
// skid FIFO, so an accepted step appears one cycle later when the FIFO is
// empty.
//
// Parameters
//   K     information bits per frame (frame = K+4 trellis steps)
//   RATE  inverse code rate: 2, 3, 4 or 6
//   SW    soft symbol width (signed two's complement)
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   i_flush      synchronous abort of the current frame
//   i_data       RATE symbols of one step, MSB-first in transmit order
//   i_valid      i_data valid
//   i_ready      a step can be accepted
//   o_llr        {0a,1a,2a,3a,1b,3b}, MSB-first
//   o_valid      o_llr valid
//   o_ready      downstream accepts the bundle
//   o_sop        bundle is step 0
//   o_eop        bundle is step K+3
//   o_tail       bundle is a termination step (K..K+3)
//   o_frame_cnt  completed frames, wrapping at 16 bits
//
// Build option
//   DEPUNCT_FRAME_CNT_EN  when defined, o_frame_cnt counts consumed end-of-frame
//                         bundles; otherwise it is tied to 0 and has no register.
// ---------------------------------------------------------------------------
module ccsds_turbo_dec_depunct #(
    parameter int K    = 8160,
    parameter int RATE = 2,
    parameter int SW   = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_flush,
    input  logic [RATE*SW-1:0]   i_data,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [6*SW-1:0]      o_llr,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_sop,
    output logic                 o_eop,
    output logic                 o_tail,
    output logic [15:0]          o_frame_cnt
);

    localparam int CW = $clog2(K + 4);
    localparam logic [CW-1:0] LAST_STEP = CW'(K + 3);
    localparam logic [CW-1:0] LAST_DATA = CW'(K - 1);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    typedef struct packed {
        logic [6*SW-1:0] llr;
        logic            sop;
        logic            eop;
        logic            tail;
    } entry_t;

    state_t          state, state_next;
    logic [CW-1:0]   step_cnt;
    logic            ready_en;
    logic            accept, consume;
    entry_t          new_entry;
    entry_t          fifo_mem [2];
    entry_t          head;
    logic            wr_ptr, rd_ptr;
    logic [1:0]      count;

    logic [SW-1:0]   sym [RATE];
    logic [SW-1:0]   s0a, s1a, s2a, s3a, s1b, s3b;

    // ready_en keeps i_ready low during reset and raises it on the first edge
    // after release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    assign i_ready = ready_en && (count < 2'd2);
    assign o_valid = (count != 2'd0);
    assign accept  = i_valid && i_ready;
    assign consume = o_valid && o_ready;

    // Split i_data into symbols; sym[0] is the first one transmitted (MSBs).
    for (genvar i = 0; i < RATE; i++) begin : g_sym
        assign sym[i] = i_data[(RATE-i)*SW-1 -: SW];
    end

    // Depuncturing map per code rate; streams that were not sent become 0.
    if (RATE == 2) begin : g_rate2
        // Rate 1/2 alternates the second symbol between streams 1a and 1b.
        // The parity restarts at 0 on every frame, independent of K's parity.
        logic parity;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)        parity <= 1'b0;
            else if (i_flush) parity <= 1'b0;
            else if (accept)  parity <= (step_cnt == LAST_STEP) ? 1'b0 : ~parity;
        end
        assign s0a = sym[0];
        assign s1a = parity ? '0 : sym[1];
        assign s1b = parity ? sym[1] : '0;
        assign s2a = '0;
        assign s3a = '0;
        assign s3b = '0;
    end else if (RATE == 3) begin : g_rate3
        assign s0a = sym[0];
        assign s1a = sym[1];
        assign s1b = sym[2];
        assign s2a = '0;
        assign s3a = '0;
        assign s3b = '0;
    end else if (RATE == 4) begin : g_rate4
        assign s0a = sym[0];
        assign s2a = sym[1];
        assign s3a = sym[2];
        assign s1b = sym[3];
        assign s1a = '0;
        assign s3b = '0;
    end else begin : g_rate6
        assign s0a = sym[0];
        assign s1a = sym[1];
        assign s2a = sym[2];
        assign s3a = sym[3];
        assign s1b = sym[4];
        assign s3b = sym[5];
    end

    // FSM state register and step counter; flush abandons the frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            step_cnt <= '0;
        end else if (i_flush) begin
            state    <= IDLE;
            step_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept)
                step_cnt <= (step_cnt == LAST_STEP) ? '0 : step_cnt + CW'(1);
        end
    end

    // Next-state logic: frame phases advance only on accepted steps.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = (step_cnt == LAST_DATA) ? TAIL : DATA;
            DATA: if (accept && step_cnt == LAST_DATA) state_next = TAIL;
            TAIL: if (accept && step_cnt == LAST_STEP) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: build the FIFO entry for the step being offered.
    always_comb begin
        new_entry      = '0;
        new_entry.llr  = {s0a, s1a, s2a, s3a, s1b, s3b};
        new_entry.sop  = (state == IDLE);
        new_entry.tail = (state == TAIL);
        new_entry.eop  = (state == TAIL) && (step_cnt == LAST_STEP);
    end

    // Two-entry skid FIFO. Accept and consume in one cycle leave count as is;
    // an accept during flush is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (i_flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= new_entry;
                wr_ptr           <= ~wr_ptr;
            end
            if (consume) rd_ptr <= ~rd_ptr;
            unique case ({accept, consume})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head   = fifo_mem[rd_ptr];
    assign o_llr  = o_valid ? head.llr : '0;
    assign o_sop  = o_valid && head.sop;
    assign o_eop  = o_valid && head.eop;
    assign o_tail = o_valid && head.tail;

`ifdef DEPUNCT_FRAME_CNT_EN
    // A frame counts as complete when its end-of-frame bundle is consumed.
    logic [15:0] frame_cnt;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                frame_cnt <= 16'd0;
        else if (consume && o_eop) frame_cnt <= frame_cnt + 16'd1;
    end
    assign o_frame_cnt = frame_cnt;
`else
    assign o_frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ccsds_turbo_dec_depunct.sv
// ---------------------------------------------------------------------------
// tb_ccsds_turbo_dec_depunct
//
// Directed bench for ccsds_turbo_dec_depunct. It uses a K=8, rate 1/2
// instance for framing, backpressure, reset and flush, and a rate 1/6
// instance for the pass-through map. The frame counter expectation follows
// DEPUNCT_FRAME_CNT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ccsds_turbo_dec_depunct;

    localparam int K  = 8;
    localparam int SW = 4;
`ifdef DEPUNCT_FRAME_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;

    logic          i_flush = 1'b0;
    logic [7:0]    i_data = '0;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [23:0]   o_llr;
    logic          o_valid;
    logic          o_ready = 1'b1;
    logic          o_sop, o_eop, o_tail;
    logic [15:0]   o_frame_cnt;

    logic          flush6 = 1'b0;
    logic [23:0]   data6 = '0;
    logic          valid6 = 1'b0;
    logic          ready6;
    logic [23:0]   llr6;
    logic          ovalid6;
    logic          oready6 = 1'b1;
    logic          sop6, eop6, tail6;
    logic [15:0]   fcnt6;

    int checks = 0;
    int errors = 0;

    ccsds_turbo_dec_depunct #(.K(K), .RATE(2), .SW(SW)) dut (
        .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_data(i_data),
        .i_valid(i_valid), .i_ready(i_ready), .o_llr(o_llr), .o_valid(o_valid),
        .o_ready(o_ready), .o_sop(o_sop), .o_eop(o_eop), .o_tail(o_tail),
        .o_frame_cnt(o_frame_cnt)
    );

    ccsds_turbo_dec_depunct #(.K(K), .RATE(6), .SW(SW)) dut6 (
        .clk(clk), .rstn(rstn), .i_flush(flush6), .i_data(data6),
        .i_valid(valid6), .i_ready(ready6), .o_llr(llr6), .o_valid(ovalid6),
        .o_ready(oready6), .o_sop(sop6), .o_eop(eop6), .o_tail(tail6),
        .o_frame_cnt(fcnt6)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                 input logic flush);
        i_valid = valid;
        i_data  = data;
        i_flush = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, o_valid, o_sop, o_eop, o_tail};
    endfunction

    // Rate 1/2 expectation: even parity -> {0a,1a}, odd parity -> {0a,1b}.
    function automatic logic [23:0] r2Llr(input logic [3:0] a, input logic [3:0] b,
                                          input bit odd);
        return odd ? {a, 12'h000, b, 4'h0} : {a, b, 16'h0000};
    endfunction

    initial begin
        // Reset state
        #12;
        checkOutput("rst_i_ready", {31'd0, i_ready}, 32'd0);
        checkOutput("rst_flags", flags(), 32'd0);
        checkOutput("rst_llr", {8'd0, o_llr}, 32'd0);
        checkOutput("rst_frame_cnt", {16'd0, o_frame_cnt}, 32'd0);
        rstn = 1'b1;
        tick();
        checkOutput("post_rst_i_ready", {31'd0, i_ready}, 32'd1);

        // Full K=8 frame, back to back, o_ready high
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'b1, {4'h1, 4'(n + 2)}, 1'b0);
            tick();
            checkOutput($sformatf("frame1_llr_%0d", n), {8'd0, o_llr},
                        {8'd0, r2Llr(4'h1, 4'(n + 2), n % 2 == 1)});
            checkOutput($sformatf("frame1_flags_%0d", n), flags(),
                        {28'd0, 1'b1, n == 0, n == 11, n >= 8});
            if (n == 11)
                checkOutput("frame1_cnt_before_eop", {16'd0, o_frame_cnt}, 32'd0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("frame1_drained", flags(), 32'd0);
        checkOutput("frame1_cnt", {16'd0, o_frame_cnt}, CNT_ON ? 32'd1 : 32'd0);

        // Rate 1/6 passes every symbol straight through
        data6  = 24'hFEDCBA;
        valid6 = 1'b1;
        checkOutput("r6_ready_a", {31'd0, ready6}, 32'd1);
        tick();
        checkOutput("r6_llr_a", {8'd0, llr6}, 32'h00FEDCBA);
        checkOutput("r6_ready_b", {31'd0, ready6}, 32'd1);
        data6 = 24'h13579B;
        tick();
        checkOutput("r6_llr_b", {8'd0, llr6}, 32'h0013579B);
        checkOutput("r6_ready_c", {31'd0, ready6}, 32'd1);
        valid6 = 1'b0;
        tick();
        checkOutput("r6_valid_idle", {31'd0, ovalid6}, 32'd0);

        // Backpressure: three steps offered while o_ready is low
        o_ready = 1'b0;
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("bp_ready_0", {31'd0, i_ready}, 32'd1);
        tick();
        applyStimulus(1'b1, 8'hB6, 1'b0);
        checkOutput("bp_ready_1", {31'd0, i_ready}, 32'd1);
        tick();
        applyStimulus(1'b1, 8'hC7, 1'b0);
        checkOutput("bp_full", {31'd0, i_ready}, 32'd0);
        tick();
        checkOutput("bp_still_full", {31'd0, i_ready}, 32'd0);
        checkOutput("bp_head_llr", {8'd0, o_llr}, 32'h00A50000);
        checkOutput("bp_head_flags", flags(), 32'b1100);
        o_ready = 1'b1;
        checkOutput("bp_ready_indep", {31'd0, i_ready}, 32'd0);
        tick();
        checkOutput("bp_ready_rise", {31'd0, i_ready}, 32'd1);
        checkOutput("bp_second_llr", {8'd0, o_llr}, 32'h00B00060);
        checkOutput("bp_second_flags", flags(), 32'b1000);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("bp_third_llr", {8'd0, o_llr}, 32'h00C70000);
        tick();
        checkOutput("bp_drained", flags(), 32'd0);

        // Reset with two bundles buffered mid-frame (steps 3 and 4)
        o_ready = 1'b0;
        applyStimulus(1'b1, 8'h23, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h24, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("pre_rst_full", {30'd0, o_valid, i_ready}, 32'b10);
        rstn = 1'b0;
        #2;
        checkOutput("mid_rst_flags", flags(), 32'd0);
        checkOutput("mid_rst_llr", {8'd0, o_llr}, 32'd0);
        checkOutput("mid_rst_cnt", {16'd0, o_frame_cnt}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, i_ready}, 32'd0);
        tick();
        checkOutput("mid_rst_ready_edge", {31'd0, i_ready}, 32'd0);
        rstn = 1'b1;
        o_ready = 1'b1;
        tick();
        checkOutput("rel_ready", {31'd0, i_ready}, 32'd1);
        checkOutput("rel_no_bundle", flags(), 32'd0);

        // Steps 0..4 of a fresh frame, then flush at step 5
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, {4'h3, 4'(n)}, 1'b0);
            tick();
            checkOutput($sformatf("pre_flush_llr_%0d", n), {8'd0, o_llr},
                        {8'd0, r2Llr(4'h3, 4'(n), n % 2 == 1)});
            checkOutput($sformatf("pre_flush_flags_%0d", n), flags(),
                        {28'd0, 1'b1, n == 0, 1'b0, 1'b0});
        end
        applyStimulus(1'b1, 8'h35, 1'b1);
        tick();
        checkOutput("flush_empty", flags(), 32'd0);

        // New frame after flush restarts at step 0 with parity 0
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'b1, {4'h4, 4'(n + 1)}, 1'b0);
            tick();
            checkOutput($sformatf("post_flush_llr_%0d", n), {8'd0, o_llr},
                        {8'd0, r2Llr(4'h4, 4'(n + 1), n % 2 == 1)});
            checkOutput($sformatf("post_flush_flags_%0d", n), flags(),
                        {28'd0, 1'b1, n == 0, n == 11, n >= 8});
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("post_flush_drained", flags(), 32'd0);
        checkOutput("post_flush_cnt", {16'd0, o_frame_cnt}, CNT_ON ? 32'd1 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
